// File: rtl/rdma_rx_hdr_queue.sv
// rdma_rx_hdr_queue: circular buffer of validated RX header records between
// the header validator and the RX control/DMA logic, plus header statistics.
// Optional statistics build: define RDMA_RX_HDR_STATS_EN to implement
// stat_ok_cnt / stat_err_cnt / stat_last_err; otherwise they read as 0.
module rdma_rx_hdr_queue #(
   parameter int DEPTH = 4,
   parameter int CNT_W = 32
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [31:0]                in_src_ip,
   input  logic [31:0]                in_dst_ip,
   input  logic [15:0]                in_src_port,
   input  logic [15:0]                in_dst_port,
   input  logic [15:0]                in_payload_len,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic                       in_error,
   input  logic [3:0]                 in_error_code,
   output logic [31:0]                out_src_ip,
   output logic [31:0]                out_dst_ip,
   output logic [15:0]                out_src_port,
   output logic [15:0]                out_dst_port,
   output logic [15:0]                out_payload_len,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [$clog2(DEPTH):0]     level,
   input  logic                       stat_clear,
   output logic [CNT_W-1:0]           stat_ok_cnt,
   output logic [CNT_W-1:0]           stat_err_cnt,
   output logic [3:0]                 stat_last_err
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;

   typedef struct packed {
      logic [31:0] src_ip;
      logic [31:0] dst_ip;
      logic [15:0] src_port;
      logic [15:0] dst_port;
      logic [15:0] payload_len;
   } hdr_t;

   hdr_t          mem [DEPTH];
   hdr_t          head;
   hdr_t          wr_rec;
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic          full;
   logic          empty;
   logic          push;
   logic          pop;

   // One extra pointer bit distinguishes full from empty when the slot indices match.
   assign level     = wr_ptr - rd_ptr;
   assign full      = (level == PW'(DEPTH));
   assign empty     = (level == '0);
   assign in_ready  = !rst && !full;
   assign out_valid = !empty;
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;

   assign wr_rec = '{src_ip: in_src_ip, dst_ip: in_dst_ip, src_port: in_src_port,
                     dst_port: in_dst_port, payload_len: in_payload_len};

   // Record storage: written on push, no reset needed since reads are masked when empty.
   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr[AW-1:0]] <= wr_rec;
   end

   // Read/write pointers; reset discards all queued records.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
      end
   end

   // Head record is read combinationally and zeroed while the queue is empty.
   always_comb begin
      head = '0;
      if (!empty)
         head = mem[rd_ptr[AW-1:0]];
   end

   assign out_src_ip      = head.src_ip;
   assign out_dst_ip      = head.dst_ip;
   assign out_src_port    = head.src_port;
   assign out_dst_port    = head.dst_port;
   assign out_payload_len = head.payload_len;

`ifdef RDMA_RX_HDR_STATS_EN
   logic [CNT_W-1:0] ok_cnt;
   logic [CNT_W-1:0] err_cnt;
   logic [3:0]       last_err;

   // Saturating statistics; a clear in the same cycle as an event drops the event.
   always_ff @(posedge clk) begin
      if (rst || stat_clear) begin
         ok_cnt   <= '0;
         err_cnt  <= '0;
         last_err <= '0;
      end else begin
         if (push && (ok_cnt != '1))
            ok_cnt <= ok_cnt + CNT_W'(1);
         if (in_error && (err_cnt != '1))
            err_cnt <= err_cnt + CNT_W'(1);
         if (in_error)
            last_err <= in_error_code;
      end
   end

   assign stat_ok_cnt   = ok_cnt;
   assign stat_err_cnt  = err_cnt;
   assign stat_last_err = last_err;
`else
   // Statistics inputs have no function in this build.
   logic unused_stat_in;
   assign unused_stat_in = stat_clear ^ in_error ^ (^in_error_code);

   assign stat_ok_cnt   = '0;
   assign stat_err_cnt  = '0;
   assign stat_last_err = '0;
`endif

endmodule

// File: tb/tb_rdma_rx_hdr_queue.sv
// Directed bench for rdma_rx_hdr_queue (DEPTH=4). Statistics expectations
// follow the RDMA_RX_HDR_STATS_EN setting of the build.
module tb_rdma_rx_hdr_queue;

`ifdef RDMA_RX_HDR_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] in_src_ip, in_dst_ip;
   logic [15:0] in_src_port, in_dst_port, in_payload_len;
   logic        in_valid, in_ready, in_error;
   logic [3:0]  in_error_code;
   logic [31:0] out_src_ip, out_dst_ip;
   logic [15:0] out_src_port, out_dst_port, out_payload_len;
   logic        out_valid, out_ready;
   logic [2:0]  level;
   logic        stat_clear;
   logic [31:0] stat_ok_cnt, stat_err_cnt;
   logic [3:0]  stat_last_err;

   int total = 0;
   int bad   = 0;
   int npush = 0;

   rdma_rx_hdr_queue #(.DEPTH(4), .CNT_W(32)) dut (
      .clk(clk), .rst(rst),
      .in_src_ip(in_src_ip), .in_dst_ip(in_dst_ip), .in_src_port(in_src_port),
      .in_dst_port(in_dst_port), .in_payload_len(in_payload_len),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_error(in_error), .in_error_code(in_error_code),
      .out_src_ip(out_src_ip), .out_dst_ip(out_dst_ip), .out_src_port(out_src_port),
      .out_dst_port(out_dst_port), .out_payload_len(out_payload_len),
      .out_valid(out_valid), .out_ready(out_ready), .level(level),
      .stat_clear(stat_clear), .stat_ok_cnt(stat_ok_cnt),
      .stat_err_cnt(stat_err_cnt), .stat_last_err(stat_last_err)
   );

   always #5 clk = ~clk;

   function automatic logic [111:0] rec(input int i);
      return {32'hA000_0000 + 32'(i), 32'hB000_0000 + 32'(i),
              16'h1000 + 16'(i), 16'h2000 + 16'(i), 16'd64 + 16'(i)};
   endfunction

   function automatic logic [111:0] head();
      return {out_src_ip, out_dst_ip, out_src_port, out_dst_port, out_payload_len};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [111:0] r);
      {in_src_ip, in_dst_ip, in_src_port, in_dst_port, in_payload_len} = r;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step(); step();
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%0b want=0", in_ready); end
      total++; if (out_valid !== 1'b0 || level !== 3'd0) begin bad++; $display("FAIL reset_state valid=%0b level=%0d want 0/0", out_valid, level); end
      total++; if (head() !== 112'd0) begin bad++; $display("FAIL reset_fields got=%h want=0", head()); end
      total++; if (stat_ok_cnt !== 0 || stat_err_cnt !== 0 || stat_last_err !== 0) begin
         bad++; $display("FAIL reset_stats ok=%0d err=%0d last=%0d want 0", stat_ok_cnt, stat_err_cnt, stat_last_err); end
      rst = 1'b0;
      #1;
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL post_reset_in_ready got=%0b want=1", in_ready); end
   endtask

   task automatic test_single_push();
      logic [111:0] r;
      r = {32'hC0A8_0001, 32'h0A00_0001, 16'd1234, 16'd5005, 16'd64};
      drive(r); in_valid = 1'b1;
      #1;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL no_bypass got=%0b want=0", out_valid); end
      step(); in_valid = 1'b0; npush++;
      total++; if (out_valid !== 1'b1 || head() !== r) begin bad++; $display("FAIL single_head valid=%0b got=%h want=%h", out_valid, head(), r); end
      total++; if (level !== 3'd1) begin bad++; $display("FAIL single_level got=%0d want=1", level); end
      total++; if (stat_ok_cnt !== (STATS ? 32'd1 : 32'd0)) begin bad++; $display("FAIL single_ok_cnt got=%0d want=%0d", stat_ok_cnt, STATS ? 1 : 0); end
      out_ready = 1'b1; step(); out_ready = 1'b0;
      total++; if (out_valid !== 1'b0 || level !== 3'd0 || head() !== 112'd0) begin
         bad++; $display("FAIL single_pop valid=%0b level=%0d head=%h want 0", out_valid, level, head()); end
   endtask

   task automatic test_full();
      for (int i = 1; i <= 4; i++) begin
         drive(rec(i)); in_valid = 1'b1; step(); npush++;
      end
      drive(rec(5));
      total++; if (level !== 3'd4 || in_ready !== 1'b0) begin bad++; $display("FAIL full_state level=%0d ready=%0b want 4/0", level, in_ready); end
      step(); step();
      total++; if (level !== 3'd4 || head() !== rec(1)) begin bad++; $display("FAIL full_hold level=%0d head=%h want 4/%h", level, head(), rec(1)); end
      out_ready = 1'b1;
      #1;
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL full_no_passthru ready=%0b want=0", in_ready); end
      step(); out_ready = 1'b0;
      total++; if (level !== 3'd3 || in_ready !== 1'b1 || head() !== rec(2)) begin
         bad++; $display("FAIL full_after_pop level=%0d ready=%0b head=%h want 3/1/%h", level, in_ready, head(), rec(2)); end
      step(); in_valid = 1'b0; npush++;
      total++; if (level !== 3'd4) begin bad++; $display("FAIL full_fifth_accept level=%0d want=4", level); end
      out_ready = 1'b1;
      for (int i = 2; i <= 5; i++) begin
         total++; if (out_valid !== 1'b1 || head() !== rec(i)) begin bad++; $display("FAIL full_order_%0d got=%h want=%h", i, head(), rec(i)); end
         step();
      end
      out_ready = 1'b0;
      total++; if (level !== 3'd0 || out_valid !== 1'b0) begin bad++; $display("FAIL full_drained level=%0d valid=%0b want 0/0", level, out_valid); end
   endtask

   task automatic test_back_to_back();
      in_valid = 1'b1;
      drive(rec(20)); step();
      drive(rec(21)); step();
      npush += 2;
      out_ready = 1'b1;
      for (int k = 0; k < 10; k++) begin
         drive(rec(22 + k));
         total++; if (level !== 3'd2 || out_valid !== 1'b1 || head() !== rec(20 + k)) begin
            bad++; $display("FAIL b2b_cycle_%0d level=%0d valid=%0b got=%h want=%h", k, level, out_valid, head(), rec(20 + k)); end
         step(); npush++;
      end
      in_valid = 1'b0;
      for (int k = 30; k < 32; k++) begin
         total++; if (head() !== rec(k)) begin bad++; $display("FAIL b2b_tail_%0d got=%h want=%h", k, head(), rec(k)); end
         step();
      end
      out_ready = 1'b0;
      total++; if (level !== 3'd0) begin bad++; $display("FAIL b2b_drained level=%0d want=0", level); end
   endtask

   task automatic test_errors();
      total++; if (stat_ok_cnt !== (STATS ? 32'(npush) : 32'd0)) begin bad++; $display("FAIL ok_cnt_total got=%0d want=%0d", stat_ok_cnt, STATS ? npush : 0); end
      in_error = 1'b1; in_error_code = 4'd5; step();
      in_error_code = 4'd7; step();
      in_error = 1'b0; in_error_code = 4'd0;
      total++; if (stat_err_cnt !== (STATS ? 32'd2 : 32'd0) || stat_last_err !== (STATS ? 4'd7 : 4'd0)) begin
         bad++; $display("FAIL err_stats err=%0d last=%0d want=%0d/%0d", stat_err_cnt, stat_last_err, STATS ? 2 : 0, STATS ? 7 : 0); end
      // Clear collides with a push and an error: the clear wins, the record still queues.
      stat_clear = 1'b1; in_valid = 1'b1; drive(rec(40)); in_error = 1'b1; in_error_code = 4'd3;
      step();
      stat_clear = 1'b0; in_valid = 1'b0; in_error = 1'b0; in_error_code = 4'd0;
      total++; if (stat_ok_cnt !== 0 || stat_err_cnt !== 0 || stat_last_err !== 0) begin
         bad++; $display("FAIL clear_wins ok=%0d err=%0d last=%0d want 0", stat_ok_cnt, stat_err_cnt, stat_last_err); end
      total++; if (level !== 3'd1 || head() !== rec(40)) begin bad++; $display("FAIL clear_push_kept level=%0d head=%h want 1/%h", level, head(), rec(40)); end
      in_valid = 1'b1; drive(rec(41)); step(); in_valid = 1'b0;
      total++; if (stat_ok_cnt !== (STATS ? 32'd1 : 32'd0)) begin bad++; $display("FAIL ok_after_clear got=%0d want=%0d", stat_ok_cnt, STATS ? 1 : 0); end
   endtask

   task automatic test_reset_mid();
      in_valid = 1'b1; drive(rec(42)); step(); in_valid = 1'b0;
      total++; if (level !== 3'd3) begin bad++; $display("FAIL mid_prefill level=%0d want=3", level); end
      rst = 1'b1;
      #1;
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL mid_rst_ready got=%0b want=0", in_ready); end
      step();
      total++; if (out_valid !== 1'b0 || level !== 3'd0 || head() !== 112'd0) begin
         bad++; $display("FAIL mid_rst_flush valid=%0b level=%0d head=%h want 0", out_valid, level, head()); end
      total++; if (stat_ok_cnt !== 0) begin bad++; $display("FAIL mid_rst_stats ok=%0d want=0", stat_ok_cnt); end
      rst = 1'b0;
      #1;
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL mid_post_ready got=%0b want=1", in_ready); end
      step();
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_no_stale got=%0b want=0", out_valid); end
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_error = 1'b0;
      in_error_code = 4'd0; stat_clear = 1'b0;
      drive(112'd0);
      test_reset();
      test_single_push();
      test_full();
      test_back_to_back();
      test_errors();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
